// File: rtl/bus_mem_target.sv
// Bus target that backs an address window with an internal word-wide memory and
// services single and burst reads/writes issued by the DMA initiator.
module bus_mem_target #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int          ADDR_WIDTH   = 10,
  parameter int          READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        begin_transaction_in,
  input  logic [31:0] address_data_in,
  input  logic        read_n_write_in,
  input  logic [7:0]  burst_size_in,
  input  logic [3:0]  byte_enables_in,
  input  logic        data_valid_in,
  input  logic        end_transaction_in,
  input  logic        busy_in,
  output logic [31:0] address_data_out,
  output logic        data_valid_out,
  output logic        end_transaction_out,
  output logic        busy_out,
  output logic        error_out
);
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int CALC_W = ADDR_WIDTH + 9;
  localparam int WAIT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = (READ_LATENCY > 2) ? WAIT_W'(READ_LATENCY - 2) : '0;
  localparam logic [CALC_W-1:0] LAST_WORD = CALC_W'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ_WAIT, READ, END, ERROR} state_t;

  state_t              state, next_state;
  logic [ADDR_WIDTH-1:0] ptr, next_ptr, base_ptr, in_ptr;
  logic [7:0]          cnt, next_cnt, base_cnt;
  logic [3:0]          byte_en, next_byte_en;
  logic [WAIT_W-1:0]   wait_cnt, next_wait_cnt;
  logic                read_done, next_read_done;
  logic                issue, mem_we, selected, overrun;
  logic [CALC_W-1:0]   end_word;
  logic [31:0]         mem [DEPTH];

  assign in_ptr   = address_data_in[ADDR_WIDTH+1:2];
  assign selected = address_data_in[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2];
  assign end_word = CALC_W'(in_ptr) + CALC_W'(burst_size_in);
  assign overrun  = end_word > LAST_WORD;

  // Output registers load from next_state, so "issue" means a read beat appears next cycle.
  always_comb begin
    next_state     = state;
    next_ptr       = ptr;
    next_cnt       = cnt;
    next_byte_en   = byte_en;
    next_wait_cnt  = wait_cnt;
    next_read_done = read_done;
    base_ptr       = ptr;
    base_cnt       = cnt;
    issue          = 1'b0;
    mem_we         = 1'b0;
    case (state)
      IDLE: begin
        if (begin_transaction_in && selected) begin
          base_ptr       = in_ptr;
          base_cnt       = burst_size_in;
          next_ptr       = in_ptr;
          next_cnt       = burst_size_in;
          next_byte_en   = byte_enables_in;
          next_wait_cnt  = WAIT_INIT;
          next_read_done = 1'b0;
          if (overrun) begin
            next_state = ERROR;
          end else if (!read_n_write_in) begin
            next_state = WRITE;
          end else if (READ_LATENCY <= 1) begin
            next_state = READ;
            issue      = !busy_in;
          end else begin
            next_state = READ_WAIT;
          end
        end
      end
      WRITE: begin
        if (data_valid_in) begin
          mem_we   = 1'b1;
          next_ptr = ptr + ADDR_WIDTH'(1);
          if (cnt == 8'd0) next_state = IDLE;
          else             next_cnt   = cnt - 8'd1;
        end
        if (end_transaction_in) next_state = IDLE;
      end
      READ_WAIT: begin
        if (end_transaction_in) begin
          next_state = IDLE;
        end else if (wait_cnt == '0) begin
          next_state = READ;
          issue      = !busy_in;
        end else begin
          next_wait_cnt = wait_cnt - WAIT_W'(1);
        end
      end
      READ: begin
        if (end_transaction_in) next_state = IDLE;
        else if (read_done)     next_state = END;
        else                    issue      = !busy_in;
      end
      END, ERROR: next_state = IDLE;
      default:    next_state = IDLE;
    endcase
    // A stalled cycle leaves the pointer alone, so the same word is offered again later.
    if (issue) begin
      next_ptr = base_ptr + ADDR_WIDTH'(1);
      if (base_cnt == 8'd0) next_read_done = 1'b1;
      else                  next_cnt       = base_cnt - 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      ptr                 <= '0;
      cnt                 <= '0;
      byte_en             <= '0;
      wait_cnt            <= '0;
      read_done           <= 1'b0;
      address_data_out    <= '0;
      data_valid_out      <= 1'b0;
      end_transaction_out <= 1'b0;
      busy_out            <= 1'b0;
      error_out           <= 1'b0;
    end else begin
      state               <= next_state;
      ptr                 <= next_ptr;
      cnt                 <= next_cnt;
      byte_en             <= next_byte_en;
      wait_cnt            <= next_wait_cnt;
      read_done           <= next_read_done;
      address_data_out    <= issue ? mem[base_ptr] : 32'd0;
      data_valid_out      <= issue;
      end_transaction_out <= next_state == END;
      busy_out            <= next_state != IDLE;
      error_out           <= next_state == ERROR;
    end
  end

  // Memory has no reset; contents survive a reset of the control logic.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[ptr][8*b +: 8] <= address_data_in[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_bus_mem_target.sv
// Scoreboard bench for bus_mem_target: stimulus tasks predict each output event and its
// cycle from a word-array model; a negedge monitor compares what the DUT presents.
module tb_bus_mem_target;
  localparam logic [31:0] BASE  = 32'h5000_0000;
  localparam int          AW    = 10;
  localparam int          LAT   = 2;
  localparam int          DEPTH = 1 << AW;
  localparam int          K_BEAT = 0, K_END = 1, K_ERR = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        begin_transaction_in, read_n_write_in, data_valid_in, end_transaction_in, busy_in;
  logic [31:0] address_data_in;
  logic [7:0]  burst_size_in;
  logic [3:0]  byte_enables_in;
  logic [31:0] address_data_out;
  logic        data_valid_out, end_transaction_out, busy_out, error_out;

  bus_mem_target #(.BASE_ADDRESS(BASE), .ADDR_WIDTH(AW), .READ_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .begin_transaction_in(begin_transaction_in), .address_data_in(address_data_in),
    .read_n_write_in(read_n_write_in), .burst_size_in(burst_size_in),
    .byte_enables_in(byte_enables_in), .data_valid_in(data_valid_in),
    .end_transaction_in(end_transaction_in), .busy_in(busy_in),
    .address_data_out(address_data_out), .data_valid_out(data_valid_out),
    .end_transaction_out(end_transaction_out), .busy_out(busy_out), .error_out(error_out)
  );

  always #5 clock = ~clock;

  typedef struct { int cyc; int kind; logic [31:0] data; } event_t;
  event_t      exp_q[$];
  event_t      mon_e;
  bit          busy_exp [int];
  logic [31:0] ref_mem [DEPTH];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Monitor: every cycle the DUT either matches the scheduled event or stays silent.
  always @(negedge clock) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL missed_event cycle=%0d actual=none required=kind%0d@%0d",
                 cyc, exp_q[0].kind, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_e = exp_q.pop_front();
        check_output("data_valid", 32'(data_valid_out), 32'(mon_e.kind == K_BEAT));
        check_output("end_pulse", 32'(end_transaction_out), 32'(mon_e.kind == K_END));
        check_output("error_pulse", 32'(error_out), 32'(mon_e.kind == K_ERR));
        if (mon_e.kind == K_BEAT) check_output("read_data", address_data_out, mon_e.data);
      end else begin
        check_output("idle_valid", 32'(data_valid_out), 32'd0);
        check_output("idle_end", 32'(end_transaction_out), 32'd0);
        check_output("idle_error", 32'(error_out), 32'd0);
      end
      if (data_valid_out !== 1'b1) check_output("data_zero", address_data_out, 32'd0);
      if (busy_exp.exists(cyc)) check_output("busy_out", 32'(busy_out), 32'(busy_exp[cyc]));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_event(input int at, input int kind, input logic [31:0] data);
    event_t e;
    e.cyc  = at;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drive_idle();
    begin_transaction_in = 1'b0;
    data_valid_in        = 1'b0;
    end_transaction_in   = 1'b0;
    busy_in              = 1'b0;
    address_data_in      = $urandom;
    read_n_write_in      = 1'($urandom);
    burst_size_in        = 8'($urandom);
    byte_enables_in      = 4'($urandom);
  endtask

  task automatic drive_begin(input logic [31:0] addr, input bit rd, input int beats, input logic [3:0] be);
    drive_idle();
    begin_transaction_in = 1'b1;
    address_data_in      = addr;
    read_n_write_in      = rd;
    burst_size_in        = 8'(beats - 1);
    byte_enables_in      = be;
  endtask

  task automatic apply_write(input logic [31:0] addr, input logic [31:0] words[$], input logic [3:0] be,
                             input int abort_after, input bit abort_beat, input bit gaps);
    int wp;
    logic [31:0] mask;
    wp   = int'(addr[AW+1:2]);
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    drive_begin(addr, 1'b0, words.size(), be);
    tick();
    for (int i = 0; i < words.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        drive_idle();
        busy_exp[cyc] = 1'b1;
        tick();
      end
      drive_idle();
      busy_exp[cyc] = 1'b1;
      if (i == abort_after) begin
        end_transaction_in = 1'b1;
        if (!abort_beat) begin
          tick();
          break;
        end
      end
      data_valid_in   = 1'b1;
      address_data_in = words[i];
      ref_mem[wp+i]   = (ref_mem[wp+i] & ~mask) | (words[i] & mask);
      tick();
      if (i == abort_after) break;
    end
    drive_idle();
    data_valid_in = 1'b1;
    busy_exp[cyc] = 1'b0;
    tick();
    drive_idle();
  endtask

  // abort_kind: 0 none, 1 end_transaction_in, 2 reset; applied once abort_at beats are out.
  task automatic apply_read(input logic [31:0] addr, input int beats, input int busy_mode,
                            input logic [31:0] busy_pattern, input int abort_kind, input int abort_at);
    int wp, sent, iter;
    bit stall;
    wp   = int'(addr[AW+1:2]);
    sent = 0;
    iter = 0;
    drive_begin(addr, 1'b1, beats, 4'($urandom));
    tick();
    for (int w = 1; w < LAT - 1; w++) begin
      drive_idle();
      busy_in       = 1'($urandom);
      busy_exp[cyc] = 1'b1;
      tick();
    end
    while (sent < beats) begin
      drive_idle();
      busy_exp[cyc] = 1'b1;
      if (abort_kind != 0 && sent == abort_at) begin
        if (abort_kind == 1) end_transaction_in = 1'b1;
        else                 reset = 1'b1;
        busy_exp[cyc+1] = 1'b0;
        tick();
        reset = 1'b0;
        drive_idle();
        return;
      end
      case (busy_mode)
        0:       stall = 1'b0;
        1:       stall = ($urandom_range(0, 2) == 0);
        default: stall = (iter < 32) ? busy_pattern[iter] : 1'b0;
      endcase
      busy_in = stall;
      if (!stall) begin
        expect_event(cyc + 1, K_BEAT, ref_mem[wp+sent]);
        sent++;
      end
      iter++;
      tick();
    end
    drive_idle();
    busy_in       = 1'($urandom);
    busy_exp[cyc] = 1'b1;
    expect_event(cyc + 1, K_END, 32'd0);
    tick();
    drive_idle();
    busy_exp[cyc] = 1'b1;
    tick();
    busy_exp[cyc] = 1'b0;
    drive_idle();
  endtask

  // For requests that must never start a transfer: outside the window or overrunning it.
  task automatic apply_stimulus(input logic [31:0] addr, input int beats, input bit rd);
    bit sel, ovr;
    sel = (addr >> (AW + 2)) == (BASE >> (AW + 2));
    ovr = sel && (int'(addr[AW+1:2]) + beats - 1 > DEPTH - 1);
    drive_begin(addr, rd, beats, 4'hF);
    tick();
    drive_idle();
    data_valid_in = 1'b1;
    if (ovr) begin
      expect_event(cyc, K_ERR, 32'd0);
      busy_exp[cyc] = 1'b1;
    end else begin
      busy_exp[cyc] = 1'b0;
    end
    tick();
    drive_idle();
    data_valid_in = 1'b1;
    busy_exp[cyc] = 1'b0;
    tick();
    drive_idle();
  endtask

  initial begin
    logic [31:0] wq[$];
    logic [31:0] addr;
    int w, n, kind, abort;

    drive_idle();
    reset = 1'b1;
    tick();
    mon_en = 1'b1;
    busy_exp[cyc] = 1'b0;
    tick();
    busy_exp[cyc] = 1'b0;
    reset = 1'b0;

    for (int blk = 0; blk < 4; blk++) begin
      wq = {};
      for (int i = 0; i < 256; i++) wq.push_back($urandom);
      apply_write(BASE + 32'(blk * 1024), wq, 4'hF, -1, 1'b0, 1'b0);
    end

    wq = {32'hDEADBEEF};
    apply_write(32'h5000_0010, wq, 4'hF, -1, 1'b0, 1'b0);
    apply_read(32'h5000_0010, 1, 0, 32'd0, 0, 0);

    wq = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    apply_write(BASE, wq, 4'hF, -1, 1'b0, 1'b0);
    wq = {32'hAABB_CCDD};
    apply_write(BASE + 32'd4, wq, 4'b0101, -1, 1'b0, 1'b0);
    apply_read(BASE, 4, 0, 32'd0, 0, 0);
    apply_read(BASE, 4, 2, 32'b0110, 0, 0);

    apply_stimulus(32'h6000_0000, 1, 1'b1);
    apply_stimulus(32'h6000_0000, 4, 1'b0);
    apply_stimulus(BASE + 32'(1022 * 4), 4, 1'b0);
    apply_read(BASE + 32'(1020 * 4), 4, 0, 32'd0, 0, 0);

    wq = {};
    for (int i = 0; i < 8; i++) wq.push_back($urandom);
    apply_write(BASE, wq, 4'hF, 3, 1'b0, 1'b0);
    apply_read(BASE, 8, 0, 32'd0, 0, 0);

    apply_read(BASE, 4, 0, 32'd0, 2, 2);
    apply_read(BASE, 4, 1, 32'd0, 0, 0);

    repeat (60) begin
      kind = $urandom_range(0, 9);
      w    = $urandom_range(0, DEPTH - 1);
      n    = $urandom_range(1, 16);
      if (w + n > DEPTH) n = DEPTH - w;
      addr = BASE | 32'(w << 2) | 32'($urandom_range(0, 3));
      if (kind < 4) begin
        wq = {};
        for (int i = 0; i < n; i++) wq.push_back($urandom);
        abort = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
        apply_write(addr, wq, 4'($urandom), abort, 1'($urandom), 1'b1);
      end else if (kind < 8) begin
        apply_read(addr, n, 1, 32'd0, ($urandom_range(0, 4) == 0) ? 1 : 0, $urandom_range(0, n - 1));
      end else if (kind == 8) begin
        addr = $urandom;
        if ((addr >> (AW + 2)) == (BASE >> (AW + 2))) addr = addr ^ 32'h8000_0000;
        apply_stimulus(addr, n, 1'($urandom));
      end else begin
        w = DEPTH - 1 - $urandom_range(0, 7);
        n = (DEPTH - w) + $urandom_range(1, 8);
        apply_stimulus(BASE | 32'(w << 2), n, 1'($urandom));
      end
    end

    drive_idle();
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
